// File: rtl/cnt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched_pkg
// Description : Shared types and helpers for the counter scheduler.
//               - sched_state_e : scheduler FSM state encoding (2 bits)
//               - idx_width()   : width of a requester index for N requesters
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched_rr_arb
// Description : Combinational round-robin pick. Chooses the first set request
//               bit at or after the pointer, wrapping modulo N.
// Ports       : i_req   [N]  request vector
//               i_ptr   [IW] round-robin start position (0..N-1)
//               o_gnt   [N]  one-hot winner (0 when no request)
//               o_idx   [IW] winner index (0 when no request)
//               o_valid      at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sched_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    o_gnt   = '0;
    w_sum   = '0;
    w_pos   = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int off = N - 1; off >= 0; off--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(off);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_pos = w_sum[IW-1:0];
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
    if (o_valid) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched
// Description : Time-shares one counter among N requesters needing a one-shot
//               timeout. A round-robin pick loads the owner's threshold, the
//               counter is cleared and enabled, and terminal count ends the job
//               with a one-cycle completion pulse.
//               FSM: IDLE -> LOAD -> RUN -> DONE -> IDLE.
// Build macro : CNT_SCHED_ABORT_EN - adds abort_i/aborted_o; an owner abort in
//               LOAD or RUN ends the job immediately.
// Ports       : clk_i, rst_ni      clock, async active-low reset
//               req_i   [N]        level requests, held until grant
//               thr_i   [N*W]      per-requester thresholds
//               gnt_o   [N]        one-hot grant pulse (LOAD)
//               done_o  [N]        one-hot completion pulse (DONE)
//               busy_o             FSM not in IDLE
//               cur_idx_o [IW]     current owner index
//               cnt_en_o/clr_o/ld_o/ld_val_o/thr_o  counter control
//               cnt_tc_i           counter terminal count
//               abort_i/aborted_o  [N] (CNT_SCHED_ABORT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32,
  localparam int IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic [N*W-1:0] thr_i,
  output logic [N-1:0]  gnt_o,
  output logic [N-1:0]  done_o,
  output logic          busy_o,
  output logic [IW-1:0] cur_idx_o,
  output logic          cnt_en_o,
  output logic          cnt_clr_o,
  output logic          cnt_ld_o,
  output logic [W-1:0]  cnt_ld_val_o,
  output logic [W-1:0]  cnt_thr_o,
`ifdef CNT_SCHED_ABORT_EN
  input  logic [N-1:0]  abort_i,
  output logic [N-1:0]  aborted_o,
`endif
  input  logic          cnt_tc_i
);

  sched_state_e  r_state;
  sched_state_e  w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_thr;
  logic [N-1:0]  r_own;     // one-hot copy of r_idx, drives gnt/done directly

  logic [N-1:0]  w_arb_gnt;
  logic [IW-1:0] w_arb_idx;
  logic          w_arb_valid;
  logic [W-1:0]  w_thr_arr [N];
  logic          w_abort;

  // Unpack the flat threshold bus into per-requester slices.
  for (genvar k = 0; k < N; k++) begin : g_thr
    assign w_thr_arr[k] = thr_i[k*W +: W];
  end

  cnt_sched_rr_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

`ifdef CNT_SCHED_ABORT_EN
  logic r_aborted;
  // Only the current owner's abort bit matters.
  assign w_abort   = |(abort_i & r_own);
  assign aborted_o = ((r_state == DONE) && r_aborted) ? r_own : '0;
`else
  assign w_abort   = 1'b0;
`endif

  // State and job registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_thr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Request sampling happens only in IDLE; later req/thr changes are ignored.
      if ((r_state == IDLE) && w_arb_valid) begin
        r_idx <= w_arb_idx;
        r_thr <= w_thr_arr[w_arb_idx];
        r_own <= w_arb_gnt;
      end
      if (r_state == DONE) begin
        r_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

`ifdef CNT_SCHED_ABORT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aborted <= 1'b0;
    end else if (((r_state == LOAD) || (r_state == RUN)) && w_abort) begin
      r_aborted <= 1'b1;
    end else if (r_state == DONE) begin
      r_aborted <= 1'b0;
    end
  end
`endif

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = '0;
    done_o      = '0;
    busy_o      = 1'b0;
    cnt_en_o    = 1'b0;
    cnt_clr_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy_o      = 1'b1;
        gnt_o       = r_own;
        cnt_clr_o   = 1'b1;
        w_state_nxt = w_abort ? DONE : RUN;
      end
      RUN: begin
        busy_o   = 1'b1;
        cnt_en_o = 1'b1;
        // Abort takes precedence but both paths land in DONE.
        if (w_abort || cnt_tc_i) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        done_o      = r_own;
        cnt_clr_o   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cur_idx_o    = r_idx;
  assign cnt_thr_o    = r_thr;   // only changes on IDLE->LOAD, so it holds between loads
  assign cnt_ld_o     = 1'b0;
  assign cnt_ld_val_o = '0;

endmodule
`default_nettype wire
